// File: rtl/vga_pixel2num.sv
// Frame-level digit recogniser. It samples nine segment points of one digit box
// per frame and decodes the lit pattern back to the digit code, colour and max flag.
module vga_pixel2num #(
  parameter int unsigned X0        = 100,
  parameter int unsigned Y0        = 100,
  parameter int unsigned W         = 40,
  parameter int unsigned H         = 80,
  parameter logic [11:0] MAX_COLOR = 12'hfe8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic [11:0] pixel,
  input  logic [11:0] bg,
  output logic [3:0]  num,
  output logic        num_valid,
  output logic [8:0]  seg_map,
  output logic [11:0] fg_color,
  output logic        max,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, COLLECT, DECODE} state_e;

  localparam logic [9:0] XL  = 10'(X0);
  localparam logic [9:0] XM  = 10'(X0 + W / 2);
  localparam logic [9:0] XR  = 10'(X0 + W);
  localparam logic [9:0] YT  = 10'(Y0);
  localparam logic [9:0] YQ1 = 10'(Y0 + H / 4);
  localparam logic [9:0] YM  = 10'(Y0 + H / 2);
  localparam logic [9:0] YQ3 = 10'(Y0 + (3 * H) / 4);
  localparam logic [9:0] YB  = 10'(Y0 + H);

  state_e      state_q;

  // Live per-frame accumulation
  logic [8:0]  lit_q, lit_d;
  logic [8:0]  mask_q, mask_d;
  logic        mix_q, mix_d;
  logic [11:0] fg_cap_q, fg_cap_d;
  logic        fg_vld_q, fg_vld_d;

  // Snapshot of the finished frame, consumed in DECODE
  logic [8:0]  snap_lit_q;
  logic [8:0]  snap_mask_q;
  logic        snap_mix_q;
  logic [11:0] snap_fg_q;

  logic [3:0]  num_q;
  logic        num_valid_q;
  logic [8:0]  seg_map_q;
  logic [11:0] fg_color_q;
  logic        max_q;
  logic        err_q;

  logic [8:0]  hit;
  logic        lit_now;
  logic        clr;
  logic        smp;
  logic [4:0]  dec;
  logic        dec_err;
  logic [3:0]  dec_num;
  logic        dec_max;

  always_comb begin
    hit = '0;
    if (pix_valid) begin
      hit[0] = (h_cnt == XM) && (v_cnt == YT);
      hit[1] = (h_cnt == XR) && (v_cnt == YQ1);
      hit[2] = (h_cnt == XR) && (v_cnt == YQ3);
      hit[3] = (h_cnt == XM) && (v_cnt == YB);
      hit[4] = (h_cnt == XL) && (v_cnt == YQ3);
      hit[5] = (h_cnt == XL) && (v_cnt == YQ1);
      hit[6] = (h_cnt == XM) && (v_cnt == YM);
      hit[7] = (h_cnt == XL) && (v_cnt == YM);
      hit[8] = (h_cnt == XR) && (v_cnt == YM);
    end
  end

  assign lit_now = (pixel != bg);
  // The clear is applied before the sample so a hit coincident with frame_start
  // lands in the new frame.
  assign clr     = frame_start && ((state_q == IDLE) || (state_q == COLLECT));
  assign smp     = (state_q != IDLE) || frame_start;

  always_comb begin
    lit_d    = lit_q;
    mask_d   = mask_q;
    mix_d    = mix_q;
    fg_cap_d = fg_cap_q;
    fg_vld_d = fg_vld_q;
    if (clr) begin
      lit_d    = '0;
      mask_d   = '0;
      mix_d    = 1'b0;
      fg_cap_d = '0;
      fg_vld_d = 1'b0;
    end
    if (smp && (hit != '0)) begin
      mask_d = mask_d | hit;
      lit_d  = lit_now ? (lit_d | hit) : (lit_d & ~hit);
      if (lit_now) begin
        if (!fg_vld_d) begin
          fg_cap_d = pixel;
          fg_vld_d = 1'b1;
        end else if (pixel != fg_cap_d) begin
          mix_d = 1'b1;
        end
      end
    end
  end

  // Bit 4 flags a pattern present in the table; low nibble is the digit code.
  function automatic logic [4:0] decode_seg(input logic [8:0] p);
    case (p)
      9'h1BF:  return {1'b1, 4'd0};
      9'h106:  return {1'b1, 4'd1};
      9'h1DB:  return {1'b1, 4'd2};
      9'h1CF:  return {1'b1, 4'd3};
      9'h1E6:  return {1'b1, 4'd4};
      9'h1ED:  return {1'b1, 4'd5};
      9'h1FD:  return {1'b1, 4'd6};
      9'h107:  return {1'b1, 4'd7};
      9'h1FF:  return {1'b1, 4'd8};
      9'h1E7:  return {1'b1, 4'd9};
      9'h1C0:  return {1'b1, 4'd10};
      9'h000:  return {1'b1, 4'd11};
      default: return {1'b0, 4'hF};
    endcase
  endfunction

  always_comb begin
    dec     = decode_seg(snap_lit_q);
    dec_err = !dec[4] || (snap_mask_q != 9'h1FF) || snap_mix_q;
    dec_num = dec_err ? 4'hF : dec[3:0];
    dec_max = !dec_err && (snap_lit_q != '0) && (snap_fg_q == MAX_COLOR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lit_q       <= '0;
      mask_q      <= '0;
      mix_q       <= 1'b0;
      fg_cap_q    <= '0;
      fg_vld_q    <= 1'b0;
      snap_lit_q  <= '0;
      snap_mask_q <= '0;
      snap_mix_q  <= 1'b0;
      snap_fg_q   <= '0;
      num_q       <= 4'd11;
      num_valid_q <= 1'b0;
      seg_map_q   <= '0;
      fg_color_q  <= '0;
      max_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      lit_q       <= lit_d;
      mask_q      <= mask_d;
      mix_q       <= mix_d;
      fg_cap_q    <= fg_cap_d;
      fg_vld_q    <= fg_vld_d;
      num_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_start) state_q <= COLLECT;
        end
        COLLECT: begin
          if (frame_start) begin
            snap_lit_q  <= lit_q;
            snap_mask_q <= mask_q;
            snap_mix_q  <= mix_q;
            snap_fg_q   <= fg_cap_q;
            state_q     <= DECODE;
          end
        end
        DECODE: begin
          num_q       <= dec_num;
          seg_map_q   <= snap_lit_q;
          fg_color_q  <= snap_fg_q;
          max_q       <= dec_max;
          err_q       <= dec_err;
          num_valid_q <= 1'b1;
          state_q     <= COLLECT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign num       = num_q;
  assign num_valid = num_valid_q;
  assign seg_map   = seg_map_q;
  assign fg_color  = fg_color_q;
  assign max       = max_q;
  assign err       = err_q;

endmodule

// File: tb/tb_vga_pixel2num.sv
// Bench for vga_pixel2num: directed frames then randomized frames, each checked
// against a frame-level reference model of the segment sampling rules.
module tb_vga_pixel2num;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [9:0]  h_cnt = '0;
  logic [9:0]  v_cnt = '0;
  logic [11:0] pixel = '0;
  logic [11:0] bg = '0;
  logic [3:0]  num;
  logic        num_valid;
  logic [8:0]  seg_map;
  logic [11:0] fg_color;
  logic        max;
  logic        err;

  always #5 clk = ~clk;

  vga_pixel2num #(.X0(100), .Y0(100), .W(40), .H(80), .MAX_COLOR(12'hfe8)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .pixel(pixel), .bg(bg),
    .num(num), .num_valid(num_valid), .seg_map(seg_map), .fg_color(fg_color),
    .max(max), .err(err)
  );

  int unsigned total = 0, passed = 0, failed = 0;
  int unsigned nv_cycles = 0, nv_mark = 0;
  always @(negedge clk) if (num_valid) nv_cycles++;

  int unsigned px[9], py[9];
  logic [8:0]  table_pat[12];

  // Reference model state for the frame being drawn
  logic [8:0]  m_mask, m_lit;
  logic [11:0] m_fg;
  bit          m_fgv, m_mix;

  // Outputs the DUT should currently be holding
  logic [3:0]  e_num;
  logic [8:0]  e_seg;
  logic [11:0] e_fg;
  logic        e_max, e_err;
  bit          armed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear;
    m_mask = '0; m_lit = '0; m_fg = '0; m_fgv = 0; m_mix = 0;
  endtask

  task automatic expect_reset_vals;
    e_num = 4'd11; e_seg = '0; e_fg = '0; e_max = 0; e_err = 0;
  endtask

  task automatic chk_outputs(input string pfx);
    chk({pfx, "_num"}, num, e_num);
    chk({pfx, "_seg"}, seg_map, e_seg);
    chk({pfx, "_fg"}, fg_color, e_fg);
    chk({pfx, "_max"}, max, e_max);
    chk({pfx, "_err"}, err, e_err);
  endtask

  function automatic bit is_point(input logic [9:0] h, input logic [9:0] v);
    for (int i = 0; i < 9; i++)
      if (h == 10'(px[i]) && v == 10'(py[i])) return 1;
    return 0;
  endfunction

  task automatic hit(input int i, input logic [11:0] p);
    h_cnt = 10'(px[i]); v_cnt = 10'(py[i]); pixel = p; pix_valid = 1;
    tick;
    pix_valid = 0;
    m_mask[i] = 1'b1;
    m_lit[i]  = (p != bg);
    if (p != bg) begin
      if (!m_fgv) begin m_fg = p; m_fgv = 1; end
      else if (p != m_fg) m_mix = 1;
    end
  endtask

  task automatic filler(input int n);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        int j = int'($urandom_range(0, 8));
        h_cnt = 10'(px[j]); v_cnt = 10'(py[j]); pix_valid = 0;
      end else begin
        h_cnt = 10'($urandom); v_cnt = 10'($urandom);
        pix_valid = 1'($urandom);
        if (is_point(h_cnt, v_cnt)) pix_valid = 0;
      end
      pixel = 12'($urandom);
      tick;
    end
    pix_valid = 0;
  endtask

  task automatic draw(input logic [8:0] pat, input logic [11:0] fgc, input logic [11:0] bgc,
                      input logic [8:0] skip, input int odd_idx, input logic [11:0] odd_col);
    logic [11:0] c;
    bg = bgc;
    for (int i = 0; i < 9; i++) begin
      filler(int'($urandom_range(0, 2)));
      c = pat[i] ? fgc : bgc;
      if (i == odd_idx) c = odd_col;
      if (skip[i]) begin
        h_cnt = 10'(px[i]); v_cnt = 10'(py[i]); pixel = c; pix_valid = 0;
        tick;
      end else begin
        hit(i, c);
      end
    end
    filler(2);
  endtask

  // Pulse frame_start; a pulse is expected only if a collected frame is pending.
  task automatic fs;
    int idx;
    bit was_armed;
    int unsigned mark0;
    logic [3:0] x_num; logic x_err, x_max;
    was_armed = armed;
    idx = -1;
    for (int k = 0; k < 12; k++) if (table_pat[k] == m_lit) idx = k;
    x_err = (m_mask != 9'h1FF) || (idx < 0) || m_mix;
    x_num = x_err ? 4'hF : 4'(idx);
    x_max = !x_err && (m_lit != '0) && (m_fg == 12'hfe8);
    chk("no_stray_valid", nv_cycles - nv_mark, 0);
    mark0 = nv_cycles;
    frame_start = 1; pix_valid = 0;
    tick;
    frame_start = 0;
    chk("valid_at_k", num_valid, 0);
    tick;
    if (was_armed) begin
      chk("valid_at_k1", num_valid, 1);
      e_num = x_num; e_seg = m_lit; e_fg = m_fg; e_max = x_max; e_err = x_err;
    end else begin
      chk("valid_idle_k1", num_valid, 0);
    end
    chk_outputs("dec");
    model_clear;
    tick;
    chk("valid_at_k2", num_valid, 0);
    chk("hold_num", num, e_num);
    chk("pulse_count", nv_cycles - mark0, was_armed ? 1 : 0);
    nv_mark = nv_cycles;
    armed = 1;
  endtask

  task automatic do_reset;
    rst_n = 0;
    tick; tick;
    rst_n = 1;
    armed = 0;
    expect_reset_vals();
    model_clear;
    chk_outputs("rst");
    chk("rst_valid", num_valid, 0);
    nv_mark = nv_cycles;
  endtask

  logic [8:0]  r_pat, r_skip;
  logic [11:0] r_fg, r_bg, r_oc;
  int          r_oi;

  initial begin
    px = '{120, 140, 140, 120, 100, 100, 120, 100, 140};
    py = '{100, 120, 160, 180, 160, 120, 140, 140, 140};
    table_pat = '{9'h1BF, 9'h106, 9'h1DB, 9'h1CF, 9'h1E6, 9'h1ED,
                  9'h1FD, 9'h107, 9'h1FF, 9'h1E7, 9'h1C0, 9'h000};
    model_clear;
    expect_reset_vals();

    do_reset;
    fs;
    draw(9'h1FF, 12'hfff, 12'h000, '0, -1, '0);
    fs;
    chk("d8_num", num, 4'd8);
    chk("d8_seg", seg_map, 9'h1FF);

    draw(9'h1CF, 12'hfff, 12'h000, '0, -1, '0);
    fs;
    chk("d3_num", num, 4'd3);
    chk("d3_fg", fg_color, 12'hfff);
    chk("d3_max", max, 0);

    draw(9'h107, 12'hfe8, 12'he7d, '0, -1, '0);
    fs;
    chk("d7_num", num, 4'd7);
    chk("d7_max", max, 1);

    draw(9'h000, 12'hfe8, 12'he7d, '0, -1, '0);
    fs;
    chk("blank_num", num, 4'd11);
    chk("blank_fg", fg_color, 12'h000);

    draw(9'h1BF, 12'h0a0, 12'h000, 9'h010, -1, '0);
    fs;
    chk("miss_err", err, 1);
    chk("miss_seg", seg_map, 9'h1AF);

    draw(9'h106, 12'h0d5, 12'h000, '0, 0, 12'hfff);
    fs;
    chk("mix_err", err, 1);
    chk("mix_num", num, 4'hF);
    chk("mix_fg", fg_color, 12'hfff);

    // Asynchronous reset in the middle of a frame
    draw(9'h1CF, 12'hfff, 12'h000, '0, -1, '0);
    fs;
    bg = 12'h000;
    hit(0, 12'hfff); hit(1, 12'hfff);
    rst_n = 0;
    #1;
    expect_reset_vals();
    chk_outputs("async_rst");
    tick;
    rst_n = 1;
    armed = 0;
    model_clear;
    nv_mark = nv_cycles;
    draw(9'h1ED, 12'h321, 12'h000, '0, -1, '0);
    fs;
    draw(9'h1ED, 12'h321, 12'h000, '0, -1, '0);
    fs;
    chk("post_rst_num", num, 4'd5);

    // Asynchronous reset while the frame is being decoded
    draw(9'h1DB, 12'h0f0, 12'h000, '0, -1, '0);
    frame_start = 1;
    tick;
    frame_start = 0;
    rst_n = 0;
    #1;
    chk("decode_rst_num", num, 4'd11);
    tick;
    rst_n = 1;
    chk("decode_rst_valid", num_valid, 0);
    tick;
    chk("decode_rst_valid2", num_valid, 0);
    armed = 0;
    model_clear;
    expect_reset_vals();
    nv_mark = nv_cycles;
    fs;

    for (int f = 0; f < 24; f++) begin
      r_pat = table_pat[$urandom_range(0, 11)];
      if ($urandom_range(0, 7) == 0) r_pat = 9'($urandom);
      r_fg = ($urandom_range(0, 3) == 0) ? 12'hfe8 : 12'($urandom);
      r_bg = r_fg ^ 12'($urandom_range(1, 4095));
      r_skip = ($urandom_range(0, 5) == 0) ? (9'd1 << $urandom_range(0, 8)) : 9'd0;
      r_oi = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 8)) : -1;
      r_oc = 12'($urandom);
      draw(r_pat, r_fg, r_bg, r_skip, r_oi, r_oc);
      if ($urandom_range(0, 3) == 0) hit(int'($urandom_range(0, 8)), 12'($urandom));
      fs;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
